// File: rtl/rf_pkg.sv
// Shared constants, FSM encoding and helpers for the 32x32 register file and its users.
// Pure definitions: no latency, no flow control.
package rf_pkg;

    localparam int REG_SIZE     = 32;
    localparam int INDEX_SIZE   = 5;
    localparam int REGFILE_SIZE = 32;

    localparam logic [INDEX_SIZE-1:0] ZERO = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2
    } fetch_state_t;

    function automatic logic [REGFILE_SIZE-1:0] onehot(input logic [INDEX_SIZE-1:0] idx);
        logic [REGFILE_SIZE-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy mask of registers with a write in flight; set beats clear on the same bit, r0 is never busy.
// Updates on the clock edge; eff_busy already excludes this cycle's writeback, no backpressure.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    set_en,
    input  logic [INDEX_SIZE-1:0]   set_idx,
    input  logic                    clr_en,
    input  logic [INDEX_SIZE-1:0]   clr_idx,
    output logic [REGFILE_SIZE-1:0] busy,
    output logic [REGFILE_SIZE-1:0] eff_busy
);

    logic [REGFILE_SIZE-1:0] busy_q;
    logic [REGFILE_SIZE-1:0] busy_d;
    logic [REGFILE_SIZE-1:0] clr_mask;
    logic [REGFILE_SIZE-1:0] set_mask;

    always_comb begin
        clr_mask = clr_en ? onehot(clr_idx) : '0;
        set_mask = (set_en && set_idx != ZERO) ? onehot(set_idx) : '0;
        eff_busy = busy_q & ~clr_mask;
        // OR-ing the set after the clear gives the new producer priority over the old one.
        busy_d   = eff_busy | set_mask;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/rf_operand_fetch.sv
// Operand fetch: reads rs/rt from rf_32 on accept, forwards same-edge writebacks, operands valid two edges later.
// Stalls issue on RAW hazards via the scoreboard; op_ready low holds VALID and keeps issue_ready low.
module rf_operand_fetch
    import rf_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic [INDEX_SIZE-1:0]   issue_rs,
    input  logic [INDEX_SIZE-1:0]   issue_rt,
    input  logic [INDEX_SIZE-1:0]   issue_rd,
    input  logic                    issue_writes,

    output logic                    rf_read_enabled,
    output logic [INDEX_SIZE-1:0]   rf_read_addr_s,
    output logic [INDEX_SIZE-1:0]   rf_read_addr_t,
    input  logic [REG_SIZE-1:0]     rf_outA,
    input  logic [REG_SIZE-1:0]     rf_outB,

    output logic                    rf_write_enabled,
    output logic [INDEX_SIZE-1:0]   rf_write_addr,
    output logic [REG_SIZE-1:0]     rf_write_data,

    input  logic                    wb_valid,
    input  logic [INDEX_SIZE-1:0]   wb_addr,
    input  logic [REG_SIZE-1:0]     wb_data,

    output logic                    op_valid,
    input  logic                    op_ready,
    output logic [REG_SIZE-1:0]     op_a,
    output logic [REG_SIZE-1:0]     op_b,
    output logic [INDEX_SIZE-1:0]   op_rd,
    output logic                    op_writes,

    output logic [REGFILE_SIZE-1:0] busy
);

    fetch_state_t state_q, state_d;

    logic                  fwd_a_q, fwd_a_d;
    logic                  fwd_b_q, fwd_b_d;
    logic [REG_SIZE-1:0]   fwd_data_q, fwd_data_d;
    logic [INDEX_SIZE-1:0] rd_q, rd_d;
    logic                  writes_q, writes_d;
    logic                  op_valid_q, op_valid_d;
    logic [REG_SIZE-1:0]   op_a_q, op_a_d;
    logic [REG_SIZE-1:0]   op_b_q, op_b_d;
    logic [INDEX_SIZE-1:0] op_rd_q, op_rd_d;
    logic                  op_writes_q, op_writes_d;

    logic [REGFILE_SIZE-1:0] eff_busy;
    logic                    accept;

    rf_scoreboard u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .set_en   (accept && issue_writes),
        .set_idx  (issue_rd),
        .clr_en   (wb_valid),
        .clr_idx  (wb_addr),
        .busy     (busy),
        .eff_busy (eff_busy)
    );

    // A writeback landing this edge releases its hazard, so the stalled instruction goes now.
    assign issue_ready = !reset && (state_q == IDLE)
                         && !eff_busy[issue_rs] && !eff_busy[issue_rt];
    assign accept      = issue_valid && issue_ready;

    assign rf_read_enabled = accept;
    assign rf_read_addr_s  = issue_rs;
    assign rf_read_addr_t  = issue_rt;

    assign rf_write_enabled = wb_valid && (wb_addr != ZERO);
    assign rf_write_addr    = wb_addr;
    assign rf_write_data    = wb_data;

    always_comb begin
        state_d     = state_q;
        fwd_a_d     = fwd_a_q;
        fwd_b_d     = fwd_b_q;
        fwd_data_d  = fwd_data_q;
        rd_d        = rd_q;
        writes_d    = writes_q;
        op_valid_d  = op_valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_rd_d     = op_rd_q;
        op_writes_d = op_writes_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = READ;
                    rd_d       = issue_rd;
                    writes_d   = issue_writes;
                    // The rf reads before it writes, so a same-edge writeback must be captured here.
                    fwd_a_d    = wb_valid && (wb_addr == issue_rs) && (issue_rs != ZERO);
                    fwd_b_d    = wb_valid && (wb_addr == issue_rt) && (issue_rt != ZERO);
                    fwd_data_d = wb_data;
                end
            end
            READ: begin
                state_d     = VALID;
                op_a_d      = fwd_a_q ? fwd_data_q : rf_outA;
                op_b_d      = fwd_b_q ? fwd_data_q : rf_outB;
                op_rd_d     = rd_q;
                op_writes_d = writes_q;
                op_valid_d  = 1'b1;
            end
            VALID: begin
                if (op_ready) begin
                    state_d    = IDLE;
                    op_valid_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                op_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fwd_a_q     <= 1'b0;
            fwd_b_q     <= 1'b0;
            fwd_data_q  <= '0;
            rd_q        <= '0;
            writes_q    <= 1'b0;
            op_valid_q  <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_rd_q     <= '0;
            op_writes_q <= 1'b0;
        end else begin
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            fwd_data_q  <= fwd_data_d;
            rd_q        <= rd_d;
            writes_q    <= writes_d;
            op_valid_q  <= op_valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_rd_q     <= op_rd_d;
            op_writes_q <= op_writes_d;
        end
    end

    assign op_valid  = op_valid_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign op_rd     = op_rd_q;
    assign op_writes = op_writes_q;

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Bench for rf_operand_fetch with a behavioural read-before-write 32x32 register file attached.
module tb_rf_operand_fetch;
    import rf_pkg::*;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    issue_valid;
    logic                    issue_ready;
    logic [INDEX_SIZE-1:0]   issue_rs, issue_rt, issue_rd;
    logic                    issue_writes;
    logic                    rf_read_enabled;
    logic [INDEX_SIZE-1:0]   rf_read_addr_s, rf_read_addr_t;
    logic [REG_SIZE-1:0]     rf_outA = '0;
    logic [REG_SIZE-1:0]     rf_outB = '0;
    logic                    rf_write_enabled;
    logic [INDEX_SIZE-1:0]   rf_write_addr;
    logic [REG_SIZE-1:0]     rf_write_data;
    logic                    wb_valid;
    logic [INDEX_SIZE-1:0]   wb_addr;
    logic [REG_SIZE-1:0]     wb_data;
    logic                    op_valid;
    logic                    op_ready;
    logic [REG_SIZE-1:0]     op_a, op_b;
    logic [INDEX_SIZE-1:0]   op_rd;
    logic                    op_writes;
    logic [REGFILE_SIZE-1:0] busy;

    int n_total = 0;
    int n_pass  = 0;

    rf_operand_fetch dut (
        .clock            (clock),
        .reset            (reset),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_rs         (issue_rs),
        .issue_rt         (issue_rt),
        .issue_rd         (issue_rd),
        .issue_writes     (issue_writes),
        .rf_read_enabled  (rf_read_enabled),
        .rf_read_addr_s   (rf_read_addr_s),
        .rf_read_addr_t   (rf_read_addr_t),
        .rf_outA          (rf_outA),
        .rf_outB          (rf_outB),
        .rf_write_enabled (rf_write_enabled),
        .rf_write_addr    (rf_write_addr),
        .rf_write_data    (rf_write_data),
        .wb_valid         (wb_valid),
        .wb_addr          (wb_addr),
        .wb_data          (wb_data),
        .op_valid         (op_valid),
        .op_ready         (op_ready),
        .op_a             (op_a),
        .op_b             (op_b),
        .op_rd            (op_rd),
        .op_writes        (op_writes),
        .busy             (busy)
    );

    always #5 clock = ~clock;

    // Register file model: outputs capture the pre-write contents on the read edge.
    logic [REG_SIZE-1:0] rf_mem [REGFILE_SIZE] = '{default: '0};
    always @(posedge clock) begin
        if (rf_read_enabled) begin
            rf_outA <= rf_mem[rf_read_addr_s];
            rf_outB <= rf_mem[rf_read_addr_t];
        end
        if (rf_write_enabled) rf_mem[rf_write_addr] <= rf_write_data;
    end

    typedef struct {
        logic [INDEX_SIZE-1:0] rs;
        logic [INDEX_SIZE-1:0] rt;
        logic [INDEX_SIZE-1:0] rd;
        logic                  w;
        logic [REG_SIZE-1:0]   a;
        logic [REG_SIZE-1:0]   b;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_issue(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic w);
        issue_valid  = 1'b1;
        issue_rs     = rs;
        issue_rt     = rt;
        issue_rd     = rd;
        issue_writes = w;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        issue_valid  = 1'b0;
        issue_rs     = '0;
        issue_rt     = '0;
        issue_rd     = '0;
        issue_writes = 1'b0;
        wb_valid     = 1'b0;
        wb_addr      = '0;
        wb_data      = '0;
        op_ready     = 1'b1;

        vecs[0] = '{rs: 5'd3,  rt: 5'd4,  rd: 5'd6,  w: 1'b0, a: 32'h0000_0011, b: 32'h0000_0022};
        vecs[1] = '{rs: 5'd1,  rt: 5'd2,  rd: 5'd7,  w: 1'b0, a: 32'h1111_0001, b: 32'h2222_0002};
        vecs[2] = '{rs: 5'd0,  rt: 5'd31, rd: 5'd1,  w: 1'b0, a: 32'h0000_0000, b: 32'hFFFF_FFFF};
        vecs[3] = '{rs: 5'd9,  rt: 5'd9,  rd: 5'd0,  w: 1'b1, a: 32'hA5A5_A5A5, b: 32'hA5A5_A5A5};
        vecs[4] = '{rs: 5'd31, rt: 5'd0,  rd: 5'd31, w: 1'b0, a: 32'hFFFF_FFFF, b: 32'h0000_0000};
        vecs[5] = '{rs: 5'd12, rt: 5'd3,  rd: 5'd2,  w: 1'b0, a: 32'h0000_0000, b: 32'h0000_0011};

        #2;
        check("reset_op_valid", {31'b0, op_valid}, 32'h0);
        check("reset_op_a", op_a, 32'h0);
        check("reset_op_b", op_b, 32'h0);
        check("reset_op_rd", {27'b0, op_rd}, 32'h0);
        check("reset_op_writes", {31'b0, op_writes}, 32'h0);
        check("reset_busy", busy, 32'h0);
        check("reset_issue_ready", {31'b0, issue_ready}, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check("post_reset_issue_ready", {31'b0, issue_ready}, 32'h1);

        // Preload through the writeback path; non-busy targets leave the scoreboard alone.
        wb_write(5'd1, 32'h1111_0001);
        wb_write(5'd2, 32'h2222_0002);
        wb_write(5'd3, 32'h0000_0011);
        wb_write(5'd4, 32'h0000_0022);
        wb_write(5'd9, 32'hA5A5_A5A5);
        wb_write(5'd31, 32'hFFFF_FFFF);
        check("preload_busy", busy, 32'h0);

        for (int i = 0; i < 6; i++) begin
            drive_issue(vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].w);
            #1;
            check($sformatf("v%0d_issue_ready", i), {31'b0, issue_ready}, 32'h1);
            check($sformatf("v%0d_rd_en", i), {31'b0, rf_read_enabled}, 32'h1);
            tick();
            issue_valid = 1'b0;
            check($sformatf("v%0d_read_op_valid", i), {31'b0, op_valid}, 32'h0);
            tick();
            check($sformatf("v%0d_op_valid", i), {31'b0, op_valid}, 32'h1);
            check($sformatf("v%0d_op_a", i), op_a, vecs[i].a);
            check($sformatf("v%0d_op_b", i), op_b, vecs[i].b);
            check($sformatf("v%0d_op_rd", i), {27'b0, op_rd}, {27'b0, vecs[i].rd});
            check($sformatf("v%0d_op_writes", i), {31'b0, op_writes}, {31'b0, vecs[i].w});
            check($sformatf("v%0d_busy", i), busy, 32'h0);
            tick();
            check($sformatf("v%0d_done", i), {31'b0, op_valid}, 32'h0);
        end

        // Basic fetch that marks r5 busy.
        drive_issue(5'd3, 5'd4, 5'd5, 1'b1);
        #1;
        check("basic_addr_s", {27'b0, rf_read_addr_s}, 32'd3);
        check("basic_addr_t", {27'b0, rf_read_addr_t}, 32'd4);
        tick();
        issue_valid = 1'b0;
        check("basic_busy", busy, 32'h0000_0020);
        tick();
        check("basic_op_a", op_a, 32'h11);
        check("basic_op_b", op_b, 32'h22);
        check("basic_op_rd", {27'b0, op_rd}, 32'd5);
        tick();

        // RAW stall released by a writeback, value forwarded on the accept edge.
        drive_issue(5'd5, 5'd3, 5'd0, 1'b0);
        #1;
        check("raw_stall_ready", {31'b0, issue_ready}, 32'h0);
        check("raw_stall_rd_en", {31'b0, rf_read_enabled}, 32'h0);
        repeat (3) tick();
        check("raw_stall_ready_held", {31'b0, issue_ready}, 32'h0);
        wb_valid = 1'b1;
        wb_addr  = 5'd5;
        wb_data  = 32'h0000_DEAD;
        #1;
        check("raw_release_ready", {31'b0, issue_ready}, 32'h1);
        check("raw_wb_en", {31'b0, rf_write_enabled}, 32'h1);
        tick();
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
        check("raw_busy_cleared", busy, 32'h0);
        tick();
        check("raw_op_a_fwd", op_a, 32'h0000_DEAD);
        check("raw_op_b", op_b, 32'h11);
        tick();

        // Destination equal to sources reads the old value.
        drive_issue(5'd5, 5'd5, 5'd5, 1'b1);
        tick();
        issue_valid = 1'b0;
        tick();
        check("self_op_a", op_a, 32'h0000_DEAD);
        check("self_op_b", op_b, 32'h0000_DEAD);
        check("self_busy", busy, 32'h0000_0020);
        tick();
        wb_write(5'd5, 32'h55);
        check("self_busy_clear", busy, 32'h0);

        // Register 0 is never written, forwarded or made busy.
        drive_issue(5'd0, 5'd0, 5'd0, 1'b1);
        wb_valid = 1'b1;
        wb_addr  = 5'd0;
        wb_data  = 32'hFF;
        #1;
        check("r0_wb_en", {31'b0, rf_write_enabled}, 32'h0);
        check("r0_ready", {31'b0, issue_ready}, 32'h1);
        tick();
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
        tick();
        check("r0_op_a", op_a, 32'h0);
        check("r0_op_b", op_b, 32'h0);
        check("r0_busy", busy, 32'h0);
        tick();

        // Backpressure holds VALID.
        op_ready = 1'b0;
        drive_issue(5'd1, 5'd2, 5'd8, 1'b0);
        tick();
        issue_valid = 1'b0;
        tick();
        check("bp_op_valid", {31'b0, op_valid}, 32'h1);
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("bp%0d_op_valid", c), {31'b0, op_valid}, 32'h1);
            check($sformatf("bp%0d_op_a", c), op_a, 32'h1111_0001);
            check($sformatf("bp%0d_op_b", c), op_b, 32'h2222_0002);
            check($sformatf("bp%0d_ready", c), {31'b0, issue_ready}, 32'h0);
        end
        op_ready = 1'b1;
        tick();
        check("bp_release_valid", {31'b0, op_valid}, 32'h0);
        check("bp_release_ready", {31'b0, issue_ready}, 32'h1);
        check("bp_release_op_a_hold", op_a, 32'h1111_0001);

        // Set/clear collision on r7: the new producer keeps it busy.
        drive_issue(5'd1, 5'd2, 5'd7, 1'b1);
        repeat (3) tick();
        issue_valid = 1'b0;
        check("coll_pre_busy", busy, 32'h0000_0080);
        drive_issue(5'd1, 5'd2, 5'd7, 1'b1);
        wb_valid = 1'b1;
        wb_addr  = 5'd7;
        wb_data  = 32'h77;
        #1;
        check("coll_ready", {31'b0, issue_ready}, 32'h1);
        tick();
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
        check("coll_busy", busy, 32'h0000_0080);
        repeat (2) tick();
        wb_write(5'd7, 32'h78);
        check("coll_busy_clear", busy, 32'h0);

        // Asynchronous reset while in READ.
        drive_issue(5'd3, 5'd4, 5'd10, 1'b1);
        tick();
        issue_valid = 1'b0;
        check("rst_pre_busy", busy, 32'h0000_0400);
        reset = 1'b1;
        #1;
        check("rst_op_valid", {31'b0, op_valid}, 32'h0);
        check("rst_busy", busy, 32'h0);
        check("rst_op_a", op_a, 32'h0);
        check("rst_op_rd", {27'b0, op_rd}, 32'h0);
        check("rst_ready_low", {31'b0, issue_ready}, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_ready_after", {31'b0, issue_ready}, 32'h1);
        tick();
        check("rst_no_stale_op", {31'b0, op_valid}, 32'h0);
        drive_issue(5'd3, 5'd4, 5'd6, 1'b0);
        tick();
        issue_valid = 1'b0;
        tick();
        check("rst_recover_op_a", op_a, 32'h11);
        check("rst_recover_op_b", op_b, 32'h22);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
